mc_controller: RTL and testbench
================================

// Module: mc_controller
// PURPOSE
//  Multicycle sequencer for the RV32I datapath. Each instruction is split into
//  FETCH/DECODE/EXEC/MEM/WB steps over one shared memory port with a req/ready handshake.
//  Drives the PC/IR write enables, the source muxes and ALU op class; resolves branches from ALU flags.
//  Flags trap conditions (illegal opcode, memory timeout) and counts retired instructions.
// PARAMETERS
//  WAIT_MAX  255  max cycles mem_req may stay unanswered before bus_err; 0 = no timeout
//  WAIT_W    8    width of wait counter; must hold WAIT_MAX
//  CNT_W     32   width of instret counter
// PORTS
//  clk         in   1      clock, all state updates on rising edge
//  reset       in   1      asynchronous, active-low reset
//  opcode      in   7      Instr[6:0] from IR
//  funct3      in   3      Instr[14:12] from IR
//  flags       in   4      ALU flags {N,Z,C,V}; C=1 means no borrow on subtract
//  mem_ready   in   1      memory completes the current access this cycle
//  mem_req     out  1      memory access request
//  mem_we      out  1      access is a write (valid only with mem_req)
//  adr_src     out  1      0: address=PC, 1: address=ALUOut
//  pc_write    out  1      load PC from Result
//  ir_write    out  1      load IR and OldPC from memory data / PC
//  reg_write   out  1      write Result to rd
//  result_src  out  2      00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt
//  alu_src_a   out  2      00 PC, 01 OldPC, 10 rs1 register
//  alu_src_b   out  2      00 rs2 register, 01 ImmExt, 10 constant 4
//  alu_op      out  2      00 add, 01 subtract/compare, 10 funct-decoded
//  illegal     out  1      sticky: unsupported opcode decoded
//  bus_err     out  1      sticky: memory timeout
//  instret     out  CNT_W  retired-instruction count, wraps to 0
// BEHAVIOUR
//  Outputs are Moore-decoded from state. Unlisted strobes are 0; unlisted muxes are 00.
//  reset low: state=FETCH, wait_cnt=0, instret=0, illegal=bus_err=0; all strobes incl. mem_req forced 0.
//  FETCH: mem_req, adr_src=0, a=00, b=10, op=00, result_src=10.
//    ir_write and pc_write assert only in the cycle mem_ready=1 (PC<=PC+4); then DECODE.
//  DECODE: a=01, b=01, op=00 (ALUOut<=OldPC+imm). Next state by opcode:
//    0000011/0100011 MEMADR; 0110011 EXECR; 0010011 EXECI; 1101111 JAL; 1100111 JALR;
//    1100011 BRANCH; 0110111 LUI; 0010111 ALUWB (auipc); any other: TRAP, illegal<=1.
//  MEMADR: a=10, b=01, op=00. Next: MEMREAD if opcode[5]=0, else MEMWRITE.
//  MEMREAD: mem_req, adr_src=1; waits for mem_ready, then MEMWB.
//  MEMWB: result_src=01, reg_write; then FETCH.
//  MEMWRITE: mem_req, mem_we, adr_src=1; waits for mem_ready, then FETCH.
//  EXECR: a=10, b=00, op=10; then ALUWB. EXECI: a=10, b=01, op=10; then ALUWB.
//  ALUWB: result_src=00, reg_write; then FETCH.
//  JAL: pc_write, result_src=00, a=01, b=10, op=00 (ALUOut<=OldPC+4); then ALUWB.
//  JALR: a=10, b=01, op=00; then JALR2.
//  JALR2: pc_write, result_src=00, a=01, b=10, op=00; then ALUWB.
//  BRANCH: a=10, b=00, op=01, result_src=00; pc_write = cond(funct3, flags); then FETCH.
//    Conditions: 000 Z; 001 !Z; 100 N^V; 101 !(N^V); 110 !C; 111 C.
//    010/011 are illegal: TRAP.
//  LUI: result_src=11, reg_write; then FETCH.
//  Wait counter: increments each cycle mem_req=1 and mem_ready=0; clears on mem_ready or on state change.
//    WAIT_MAX!=0 and wait_cnt==WAIT_MAX with mem_ready=0: TRAP, bus_err<=1. mem_ready wins on the same cycle.
//  TRAP: all strobes 0; held until reset; illegal/bus_err stay set.
//  instret +1 on every transition into FETCH from MEMWB, MEMWRITE, ALUWB, BRANCH or LUI.
//  mem_ready is ignored when mem_req=0. Reset mid-access abandons it; the first request after reset is a FETCH.
// TESTING
//  Zero-wait memory, addi then add -> each takes 4 cycles (FETCH,DECODE,EXECx,ALUWB); instret=2.
//  lw with mem_ready delayed 3 cycles in MEMREAD -> mem_req held 4 cycles, adr_src=1; reg_write one cycle.
//  beq: flags Z=1 -> pc_write in BRANCH; Z=0 -> no pc_write. bltu with C=0 -> pc_write=1.
//  jalr -> states JALR, JALR2, ALUWB; pc_write only in JALR2; reg_write only in ALUWB.
//  Opcode 0000000 -> TRAP, illegal=1 persists. WAIT_MAX=4, mem_ready never set -> bus_err after 5 req cycles.
//  reset low mid-MEMWRITE -> mem_req=0 immediately; after release FETCH requests with adr_src=0, instret=0.

Source files
------------

// File: rtl/mc_controller.sv
// Multicycle RV32I control sequencer: steps each instruction through FETCH..WB over a
// shared req/ready memory port, resolves branches from ALU flags, traps and counts retires.
`timescale 1ns/1ps
module mc_controller #(
  parameter int unsigned WAIT_MAX = 255,
  parameter int unsigned WAIT_W   = 8,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [3:0]       flags,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             adr_src,
  output logic             pc_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR, S_EXECI,
    S_ALUWB, S_JAL, S_JALR, S_JALR2, S_BRANCH, S_LUI, S_TRAP
  } state_t;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [CNT_W-1:0]    instret_q, instret_d;
  logic                illegal_q, illegal_d;
  logic                bus_err_q, bus_err_d;

  logic                req_c, we_c, adr_c, pcw_c, irw_c, rw_c;
  logic [1:0]          rs_c, a_c, b_c, op_c;
  logic                n_f, z_f, c_f, v_f;
  logic                br_taken;

  assign {n_f, z_f, c_f, v_f} = flags;

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = z_f;
      3'b001:  br_taken = ~z_f;
      3'b100:  br_taken = n_f ^ v_f;
      3'b101:  br_taken = ~(n_f ^ v_f);
      3'b110:  br_taken = ~c_f;
      3'b111:  br_taken = c_f;
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    req_c = 1'b0; we_c = 1'b0; adr_c = 1'b0;
    pcw_c = 1'b0; irw_c = 1'b0; rw_c = 1'b0;
    rs_c  = 2'b00; a_c = 2'b00; b_c = 2'b00; op_c = 2'b00;

    case (state_q)
      S_FETCH: begin
        req_c = 1'b1; b_c = 2'b10; rs_c = 2'b10;
        if (mem_ready) begin
          irw_c   = 1'b1;
          pcw_c   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_c = 2'b01; b_c = 2'b01;
        case (opcode)
          7'b0000011, 7'b0100011: state_d = S_MEMADR;
          7'b0110011:             state_d = S_EXECR;
          7'b0010011:             state_d = S_EXECI;
          7'b1101111:             state_d = S_JAL;
          7'b1100111:             state_d = S_JALR;
          7'b1100011:             state_d = S_BRANCH;
          7'b0110111:             state_d = S_LUI;
          7'b0010111:             state_d = S_ALUWB;
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        a_c = 2'b10; b_c = 2'b01;
        state_d = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        req_c = 1'b1; adr_c = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        rs_c = 2'b01; rw_c = 1'b1;
        state_d = S_FETCH;
      end
      S_MEMWRITE: begin
        req_c = 1'b1; we_c = 1'b1; adr_c = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        a_c = 2'b10; b_c = 2'b00; op_c = 2'b10;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        a_c = 2'b10; b_c = 2'b01; op_c = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        rw_c = 1'b1;
        state_d = S_FETCH;
      end
      S_JAL, S_JALR2: begin
        pcw_c = 1'b1; a_c = 2'b01; b_c = 2'b10;
        state_d = S_ALUWB;
      end
      S_JALR: begin
        a_c = 2'b10; b_c = 2'b01;
        state_d = S_JALR2;
      end
      S_BRANCH: begin
        a_c = 2'b10; b_c = 2'b00; op_c = 2'b01;
        // funct3 010/011 have no branch meaning; they trap without redirecting the PC
        if (funct3[2:1] == 2'b01) begin
          state_d   = S_TRAP;
          illegal_d = 1'b1;
        end else begin
          pcw_c   = br_taken;
          state_d = S_FETCH;
        end
      end
      S_LUI: begin
        rs_c = 2'b11; rw_c = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase

    if ((WAIT_MAX != 0) && req_c && !mem_ready && (wait_q == WAIT_W'(WAIT_MAX))) begin
      state_d   = S_TRAP;
      bus_err_d = 1'b1;
    end

    if ((req_c && mem_ready) || (state_d != state_q)) wait_d = '0;
    else if (req_c)                                   wait_d = wait_q + WAIT_W'(1);
    else                                              wait_d = wait_q;

    instret_d = instret_q;
    if ((state_d == S_FETCH) &&
        (state_q inside {S_MEMWB, S_MEMWRITE, S_ALUWB, S_BRANCH, S_LUI}))
      instret_d = instret_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      instret_q <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      instret_q <= instret_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Strobes are gated directly by reset so they drop the instant reset goes low
  assign mem_req    = req_c & reset;
  assign mem_we     = we_c  & reset;
  assign adr_src    = adr_c & reset;
  assign pc_write   = pcw_c & reset;
  assign ir_write   = irw_c & reset;
  assign reg_write  = rw_c  & reset;
  assign result_src = reset ? rs_c : 2'b00;
  assign alu_src_a  = reset ? a_c  : 2'b00;
  assign alu_src_b  = reset ? b_c  : 2'b00;
  assign alu_op     = reset ? op_c : 2'b00;
  assign illegal    = illegal_q;
  assign bus_err    = bus_err_q;
  assign instret    = instret_q;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: per-instruction step templates with random memory latency,
// operands and branch flags derived from real subtraction, plus trap/timeout/reset scenarios.
`timescale 1ns/1ps
module tb_mc_controller;
  localparam int unsigned WMAX = 4;
  localparam int unsigned CW   = 4;

  localparam int K_LOAD = 0, K_STORE = 1, K_R = 2, K_I = 3, K_JAL = 4,
                 K_JALR = 5, K_BR = 6, K_LUI = 7, K_AUIPC = 8;

  // {req,we,adr,pcw,irw,rw, result_src, a, b, op}
  localparam logic [13:0] V_FETCH_W = {6'b100000, 2'b10, 2'b00, 2'b10, 2'b00};
  localparam logic [13:0] V_FETCH_R = {6'b100110, 2'b10, 2'b00, 2'b10, 2'b00};
  localparam logic [13:0] V_DEC     = {6'b000000, 2'b00, 2'b01, 2'b01, 2'b00};
  localparam logic [13:0] V_MEMADR  = {6'b000000, 2'b00, 2'b10, 2'b01, 2'b00};
  localparam logic [13:0] V_MEMRD   = {6'b101000, 8'b0};
  localparam logic [13:0] V_MEMWB   = {6'b000001, 2'b01, 6'b0};
  localparam logic [13:0] V_MEMWR   = {6'b111000, 8'b0};
  localparam logic [13:0] V_EXR     = {6'b000000, 2'b00, 2'b10, 2'b00, 2'b10};
  localparam logic [13:0] V_EXI     = {6'b000000, 2'b00, 2'b10, 2'b01, 2'b10};
  localparam logic [13:0] V_ALUWB   = {6'b000001, 8'b0};
  localparam logic [13:0] V_JMP     = {6'b000100, 2'b00, 2'b01, 2'b10, 2'b00};
  localparam logic [13:0] V_JALR1   = {6'b000000, 2'b00, 2'b10, 2'b01, 2'b00};
  localparam logic [13:0] V_LUI     = {6'b000001, 2'b11, 6'b0};

  logic          clk = 1'b0;
  logic          reset;
  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic [3:0]    flags;
  logic          mem_ready;
  logic          mem_req, mem_we, adr_src, pc_write, ir_write, reg_write;
  logic [1:0]    result_src, alu_src_a, alu_src_b, alu_op;
  logic          illegal, bus_err;
  logic [CW-1:0] instret;
  logic [13:0]   obs;

  int            checks = 0;
  int            failures = 0;
  logic [CW-1:0] exp_ret;
  logic [13:0]   exp_q[$];
  bit            rdy_q[$];
  string         kname[9] = '{"lw", "sw", "rtype", "itype", "jal", "jalr", "branch", "lui", "auipc"};
  logic [2:0]    br_f3[6] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};

  always #5 clk = ~clk;

  mc_controller #(.WAIT_MAX(WMAX), .WAIT_W(4), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .flags(flags),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src),
    .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .illegal(illegal), .bus_err(bus_err), .instret(instret)
  );

  assign obs = {mem_req, mem_we, adr_src, pc_write, ir_write, reg_write,
                result_src, alu_src_a, alu_src_b, alu_op};

  function automatic void push_other(input logic [13:0] v);
    exp_q.push_back(v);
    rdy_q.push_back(1'($urandom_range(0, 1)));
  endfunction

  function automatic void push_mem(input logic [13:0] v_wait, input logic [13:0] v_done, input int w);
    for (int i = 0; i < w; i++) begin
      exp_q.push_back(v_wait);
      rdy_q.push_back(1'b0);
    end
    exp_q.push_back(v_done);
    rdy_q.push_back(1'b1);
  endfunction

  task automatic test_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    mem_ready = 1'($urandom_range(0, 1));
    #1 checks++;
    if ({obs, illegal, bus_err, instret} !== '0) begin
      failures++;
      $display("FAIL reset_async: got out=%b ill=%b err=%b instret=%0d expected all zero",
               obs, illegal, bus_err, instret);
    end
    repeat (2) @(posedge clk);
    #1 checks++;
    if ({obs, illegal, bus_err, instret} !== '0) begin
      failures++;
      $display("FAIL reset_held: got out=%b ill=%b err=%b instret=%0d expected all zero",
               obs, illegal, bus_err, instret);
    end
    #1 reset = 1'b1;
    mem_ready = 1'b0;
    exp_ret = '0;
  endtask

  task automatic exec_instr(input int kind, input int fw, input int mw,
                            input logic [31:0] ra, input logic [31:0] rb, input logic [2:0] f3);
    logic [6:0]  opc;
    logic [31:0] diff;
    logic [3:0]  fl;
    bit          taken;
    exp_q.delete();
    rdy_q.delete();
    diff = ra - rb;
    fl = $urandom_range(0, 15);
    taken = 1'b0;
    push_mem(V_FETCH_W, V_FETCH_R, fw);
    push_other(V_DEC);
    case (kind)
      K_LOAD:  begin opc = 7'b0000011; push_other(V_MEMADR); push_mem(V_MEMRD, V_MEMRD, mw); push_other(V_MEMWB); end
      K_STORE: begin opc = 7'b0100011; push_other(V_MEMADR); push_mem(V_MEMWR, V_MEMWR, mw); end
      K_R:     begin opc = 7'b0110011; push_other(V_EXR); push_other(V_ALUWB); end
      K_I:     begin opc = 7'b0010011; push_other(V_EXI); push_other(V_ALUWB); end
      K_JAL:   begin opc = 7'b1101111; push_other(V_JMP); push_other(V_ALUWB); end
      K_JALR:  begin opc = 7'b1100111; push_other(V_JALR1); push_other(V_JMP); push_other(V_ALUWB); end
      K_BR: begin
        opc = 7'b1100011;
        fl = {diff[31], diff == 32'd0, ra >= rb, (ra[31] != rb[31]) && (diff[31] != ra[31])};
        case (f3)
          3'b000:  taken = (ra == rb);
          3'b001:  taken = (ra != rb);
          3'b100:  taken = ($signed(ra) < $signed(rb));
          3'b101:  taken = ($signed(ra) >= $signed(rb));
          3'b110:  taken = (ra < rb);
          default: taken = (ra >= rb);
        endcase
        push_other({3'b000, taken, 2'b00, 2'b00, 2'b10, 2'b00, 2'b01});
      end
      K_LUI:   begin opc = 7'b0110111; push_other(V_LUI); end
      default: begin opc = 7'b0010111; push_other(V_ALUWB); end
    endcase
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      if (k == 0) begin
        opcode = opc;
        funct3 = (kind == K_BR) ? f3 : 3'($urandom_range(0, 7));
        flags  = fl;
      end
      mem_ready = rdy_q[k];
      #1;
      if (k == 0) begin
        checks++;
        if ({illegal, bus_err, instret} !== {2'b00, exp_ret}) begin
          failures++;
          $display("FAIL status_%s: got ill=%b err=%b instret=%0d expected 0 0 %0d",
                   kname[kind], illegal, bus_err, instret, exp_ret);
        end
      end
      checks++;
      if (obs !== exp_q[k]) begin
        failures++;
        $display("FAIL %s step %0d (fw=%0d mw=%0d f3=%b): got %b expected %b",
                 kname[kind], k, fw, mw, f3, obs, exp_q[k]);
      end
    end
    exp_ret = exp_ret + 1'b1;
  endtask

  task automatic test_alu();
    test_reset();
    exec_instr(K_I, 0, 0, $urandom, $urandom, 3'b000);
    exec_instr(K_R, 0, 0, $urandom, $urandom, 3'b000);
    @(negedge clk);
    mem_ready = 1'b0;
    #1 checks++;
    if (instret !== 4'd2) begin
      failures++;
      $display("FAIL alu_instret: got %0d expected 2", instret);
    end
  endtask

  task automatic test_load_store();
    test_reset();
    exec_instr(K_LOAD, 0, 3, $urandom, $urandom, 3'b010);
    exec_instr(K_STORE, 2, 1, $urandom, $urandom, 3'b010);
    exec_instr(K_LOAD, WMAX, WMAX, $urandom, $urandom, 3'b010);
    exec_instr(K_STORE, 0, 0, $urandom, $urandom, 3'b010);
  endtask

  task automatic test_branch();
    logic [31:0] a;
    test_reset();
    a = $urandom;
    exec_instr(K_BR, 0, 0, a, a, 3'b000);
    exec_instr(K_BR, 1, 0, a, a + 32'd5, 3'b000);
    exec_instr(K_BR, 0, 0, 32'd3, 32'd9, 3'b110);
    exec_instr(K_BR, 0, 0, 32'hFFFF_FFFF, 32'd1, 3'b100);
    exec_instr(K_BR, 0, 0, 32'h8000_0000, 32'h7FFF_FFFF, 3'b101);
    exec_instr(K_BR, 0, 0, 32'd9, 32'd3, 3'b111);
  endtask

  task automatic test_jump();
    test_reset();
    exec_instr(K_JALR, 0, 0, $urandom, $urandom, 3'b000);
    exec_instr(K_JAL, 1, 0, $urandom, $urandom, 3'b000);
    exec_instr(K_LUI, 0, 0, $urandom, $urandom, 3'b000);
    exec_instr(K_AUIPC, 0, 0, $urandom, $urandom, 3'b000);
  endtask

  task automatic test_back_to_back();
    logic [31:0] ra, rb;
    test_reset();
    repeat (150) begin
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      exec_instr($urandom_range(0, 8), $urandom_range(0, WMAX), $urandom_range(0, WMAX),
                 ra, rb, br_f3[$urandom_range(0, 5)]);
    end
    @(negedge clk);
    mem_ready = 1'b0;
    #1 checks++;
    if (instret !== exp_ret) begin
      failures++;
      $display("FAIL b2b_instret: got %0d expected %0d", instret, exp_ret);
    end
  endtask

  task automatic test_trap();
    for (int c = 0; c < 3; c++) begin
      test_reset();
      opcode = (c == 0) ? 7'b0000000 : 7'b1100011;
      funct3 = (c == 1) ? 3'b010 : 3'b011;
      flags  = $urandom_range(0, 15);
      exp_q.delete();
      rdy_q.delete();
      push_mem(V_FETCH_W, V_FETCH_R, $urandom_range(0, 2));
      push_other(V_DEC);
      if (c > 0) push_other({6'b000000, 2'b00, 2'b10, 2'b00, 2'b01});
      for (int k = 0; k < exp_q.size(); k++) begin
        @(negedge clk);
        mem_ready = rdy_q[k];
        #1 checks++;
        if (obs !== exp_q[k]) begin
          failures++;
          $display("FAIL trap%0d step %0d: got %b expected %b", c, k, obs, exp_q[k]);
        end
      end
      repeat (3) begin
        @(negedge clk);
        mem_ready = 1'($urandom_range(0, 1));
        #1 checks++;
        if ({obs, illegal, bus_err, instret} !== {14'b0, 2'b10, 4'd0}) begin
          failures++;
          $display("FAIL trap%0d hold: got out=%b ill=%b err=%b instret=%0d expected out=0 ill=1 err=0 instret=0",
                   c, obs, illegal, bus_err, instret);
        end
      end
    end
  endtask

  task automatic test_timeout();
    for (int c = 0; c < 2; c++) begin
      test_reset();
      opcode = 7'b0000011;
      funct3 = 3'b010;
      exp_q.delete();
      rdy_q.delete();
      if (c == 0) begin
        for (int i = 0; i <= WMAX; i++) begin exp_q.push_back(V_FETCH_W); rdy_q.push_back(1'b0); end
      end else begin
        push_mem(V_FETCH_W, V_FETCH_R, 0);
        push_other(V_DEC);
        push_other(V_MEMADR);
        for (int i = 0; i <= WMAX; i++) begin exp_q.push_back(V_MEMRD); rdy_q.push_back(1'b0); end
      end
      for (int k = 0; k < exp_q.size(); k++) begin
        @(negedge clk);
        mem_ready = rdy_q[k];
        #1 checks++;
        if ({obs, bus_err} !== {exp_q[k], 1'b0}) begin
          failures++;
          $display("FAIL timeout%0d step %0d: got out=%b err=%b expected out=%b err=0",
                   c, k, obs, bus_err, exp_q[k]);
        end
      end
      repeat (3) begin
        @(negedge clk);
        mem_ready = 1'($urandom_range(0, 1));
        #1 checks++;
        if ({obs, illegal, bus_err, instret} !== {14'b0, 2'b01, 4'd0}) begin
          failures++;
          $display("FAIL timeout%0d hold: got out=%b ill=%b err=%b instret=%0d expected out=0 ill=0 err=1 instret=0",
                   c, obs, illegal, bus_err, instret);
        end
      end
    end
  endtask

  task automatic test_reset_mid_write();
    test_reset();
    exec_instr(K_I, 0, 0, $urandom, $urandom, 3'b000);
    exec_instr(K_R, 1, 0, $urandom, $urandom, 3'b000);
    exp_q.delete();
    rdy_q.delete();
    push_mem(V_FETCH_W, V_FETCH_R, 1);
    push_other(V_DEC);
    push_other(V_MEMADR);
    for (int i = 0; i < 2; i++) begin exp_q.push_back(V_MEMWR); rdy_q.push_back(1'b0); end
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      if (k == 0) opcode = 7'b0100011;
      mem_ready = rdy_q[k];
      #1 checks++;
      if ({obs, instret} !== {exp_q[k], 4'd2}) begin
        failures++;
        $display("FAIL midwrite step %0d: got out=%b instret=%0d expected out=%b instret=2",
                 k, obs, instret, exp_q[k]);
      end
    end
    #2 reset = 1'b0;
    #1 checks++;
    if ({obs, instret} !== '0) begin
      failures++;
      $display("FAIL midwrite_abort: got out=%b instret=%0d expected out=0 instret=0", obs, instret);
    end
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    #1 checks++;
    if ({obs, illegal, bus_err, instret} !== {V_FETCH_W, 2'b00, 4'd0}) begin
      failures++;
      $display("FAIL midwrite_refetch: got out=%b ill=%b err=%b instret=%0d expected out=%b instret=0",
               obs, illegal, bus_err, instret, V_FETCH_W);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    mem_ready = 1'b0;
    opcode = '0;
    funct3 = '0;
    flags = '0;
    exp_ret = '0;
    test_reset();
    test_alu();
    test_load_store();
    test_branch();
    test_jump();
    test_back_to_back();
    test_trap();
    test_timeout();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
